// File: rtl/load_store_unit.sv
// Data-memory stage: turns a decoded load/store into one or two word beats on a
// req/ack bus and returns the lane-shifted, sign- or zero-extended load result.
module load_store_unit #(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_enable,
  input  logic        op_valid,
  input  logic        op_store,
  input  logic [1:0]  op_size,
  input  logic        op_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

  state_t      r_state, w_nextState;
  logic        r_store, r_unsigned;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_sdata, r_rbuf;

  logic        w_capture, w_busy, w_loadValid, w_fault, w_memReq, w_memWe;
  logic [29:0] w_memAddr;
  logic [31:0] w_memWdata, w_loadData, w_rbuf;
  logic [3:0]  w_memWmask;
  logic [3:0]  w_inMask, w_hiMask;
  logic [31:0] w_inData, w_hiData;

  function automatic logic [2:0] sizeBytes(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic crosses(input logic [1:0] off, input logic [1:0] size);
    return ({1'b0, off} + sizeBytes(size)) > 3'd4;
  endfunction

  // Lanes/data for both beats at once: low half is beat 0, high half is beat 1.
  function automatic logic [7:0] laneMask(input logic [1:0] off, input logic [1:0] size);
    logic [3:0] bm;
    case (size)
      2'd0:    bm = 4'h1;
      2'd1:    bm = 4'h3;
      default: bm = 4'hF;
    endcase
    return {4'b0, bm} << off;
  endfunction

  function automatic logic [63:0] laneData(input logic [1:0] off, input logic [31:0] data);
    return {32'b0, data} << {off, 3'b000};
  endfunction

  function automatic logic [31:0] extendLoad(input logic [63:0] raw, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
    logic [31:0] w;
    w = 32'(raw >> {off, 3'b000});
    case (size)
      2'd0:    return uns ? {24'b0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
      2'd1:    return uns ? {16'b0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  always_comb begin
    w_inMask    = 4'(laneMask(addr[1:0], op_size));
    w_inData    = 32'(laneData(addr[1:0], store_data));
    w_hiMask    = 4'(laneMask(r_addr[1:0], r_size) >> 4);
    w_hiData    = 32'(laneData(r_addr[1:0], r_sdata) >> 32);
    w_nextState = r_state;
    w_capture   = 1'b0;
    w_memReq    = mem_req;
    w_memWe     = mem_we;
    w_memAddr   = mem_addr;
    w_memWdata  = mem_wdata;
    w_memWmask  = mem_wmask;
    w_loadValid = 1'b0;
    w_fault     = 1'b0;
    w_loadData  = load_data;
    w_rbuf      = r_rbuf;
    case (r_state)
      IDLE: begin
        if (op_valid) begin
          w_capture = 1'b1;
          if (!SPLIT_MISALIGNED && crosses(addr[1:0], op_size)) begin
            w_nextState = DONE;
            w_fault     = 1'b1;
          end else begin
            w_nextState = ACC0;
            w_memReq    = 1'b1;
            w_memWe     = op_store;
            w_memAddr   = addr[31:2];
            w_memWmask  = w_inMask;
            w_memWdata  = w_inData;
          end
        end
      end
      ACC0: begin
        if (mem_ack) begin
          if (crosses(r_addr[1:0], r_size)) begin
            w_nextState = ACC1;
            w_rbuf      = mem_rdata;
            w_memAddr   = r_addr[31:2] + 30'd1;
            w_memWmask  = w_hiMask;
            w_memWdata  = w_hiData;
          end else begin
            w_nextState = DONE;
            w_memReq    = 1'b0;
            w_memWe     = 1'b0;
            if (!r_store) begin
              w_loadValid = 1'b1;
              w_loadData  = extendLoad({32'b0, mem_rdata}, r_addr[1:0], r_size, r_unsigned);
            end
          end
        end
      end
      ACC1: begin
        if (mem_ack) begin
          w_nextState = DONE;
          w_memReq    = 1'b0;
          w_memWe     = 1'b0;
          if (!r_store) begin
            w_loadValid = 1'b1;
            w_loadData  = extendLoad({mem_rdata, r_rbuf}, r_addr[1:0], r_size, r_unsigned);
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
    w_busy = (w_nextState != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      busy       <= 1'b0;
      load_valid <= 1'b0;
      fault      <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      load_data  <= 32'b0;
      mem_addr   <= 30'b0;
      mem_wdata  <= 32'b0;
      mem_wmask  <= 4'b0;
      r_rbuf     <= 32'b0;
    end else if (clk_enable) begin
      r_state    <= w_nextState;
      busy       <= w_busy;
      load_valid <= w_loadValid;
      fault      <= w_fault;
      mem_req    <= w_memReq;
      mem_we     <= w_memWe;
      load_data  <= w_loadData;
      mem_addr   <= w_memAddr;
      mem_wdata  <= w_memWdata;
      mem_wmask  <= w_memWmask;
      r_rbuf     <= w_rbuf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_store    <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= 2'b0;
      r_addr     <= 32'b0;
      r_sdata    <= 32'b0;
    end else if (clk_enable && w_capture) begin
      r_store    <= op_store;
      r_unsigned <= op_unsigned;
      r_size     <= op_size;
      r_addr     <= addr;
      r_sdata    <= store_data;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: random and directed loads/stores against a
// byte-addressed reference memory, plus stall, reset and no-split cases.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst, clk_enable, op_valid, op_store, op_unsigned;
  logic [1:0]  op_size;
  logic [31:0] addr, store_data;
  logic        busy, load_valid, fault, mem_req, mem_we, mem_ack;
  logic [31:0] load_data, mem_wdata, mem_rdata;
  logic [29:0] mem_addr;
  logic [3:0]  mem_wmask;

  logic        u1OpValid, u1MemAck;
  logic        u1Busy, u1LoadValid, u1Fault, u1MemReq, u1MemWe;
  logic [31:0] u1LoadData, u1MemWdata;
  logic [29:0] u1MemAddr;
  logic [3:0]  u1MemWmask;

  int compareCount = 0;
  int mismatchCount = 0;

  logic [31:0] busMem [logic [29:0]];
  logic [7:0]  refMem [logic [31:0]];

  always #5 clk = ~clk;

  load_store_unit #(.SPLIT_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst(rst), .clk_enable(clk_enable), .op_valid(op_valid),
    .op_store(op_store), .op_size(op_size), .op_unsigned(op_unsigned),
    .addr(addr), .store_data(store_data), .busy(busy), .load_data(load_data),
    .load_valid(load_valid), .fault(fault), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  load_store_unit #(.SPLIT_MISALIGNED(1'b0)) dutNoSplit (
    .clk(clk), .rst(rst), .clk_enable(clk_enable), .op_valid(u1OpValid),
    .op_store(op_store), .op_size(op_size), .op_unsigned(op_unsigned),
    .addr(addr), .store_data(store_data), .busy(u1Busy), .load_data(u1LoadData),
    .load_valid(u1LoadValid), .fault(u1Fault), .mem_req(u1MemReq), .mem_we(u1MemWe),
    .mem_addr(u1MemAddr), .mem_wdata(u1MemWdata), .mem_wmask(u1MemWmask),
    .mem_ack(u1MemAck), .mem_rdata(mem_rdata)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic setWord(input logic [29:0] wa, input logic [31:0] w);
    busMem[wa] = w;
    for (int b = 0; b < 4; b++) refMem[{wa, 2'(b)}] = w[8*b +: 8];
  endtask

  // One request; the bus responder acks each beat after ackDelay wait cycles and
  // optionally freezes the block for two cycles with mem_ack forced high.
  task automatic applyStimulus(input logic st, input logic [1:0] sz, input logic un,
                               input logic [31:0] a, input logic [31:0] d,
                               input int ackDelay, input int stallAt,
                               output logic [31:0] lastLoad);
    int nBytes, expN, gotN, waitCnt, lvCount, lvCycle, faultCount, endCycle, expLv;
    logic [29:0] expAddr [2];
    logic [3:0]  expMask [2];
    logic [31:0] expData [2];
    logic [29:0] gotAddr [4];
    logic [3:0]  gotMask [4];
    logic [31:0] gotData [4];
    logic        gotWe   [4];
    logic [31:0] ba, expLoad, tmp, bits;
    logic [29:0] beatAddr;
    logic        inBeat;

    nBytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    expN = 0;
    expLoad = 32'b0;
    beatAddr = 30'b0;
    for (int i = 0; i < nBytes; i++) begin
      ba = a + 32'(i);
      if (expN == 0 || expAddr[expN-1] != ba[31:2]) begin
        expAddr[expN] = ba[31:2];
        expMask[expN] = 4'b0;
        expData[expN] = 32'b0;
        expN++;
      end
      expMask[expN-1] = expMask[expN-1] | (4'b1 << ba[1:0]);
      tmp = expData[expN-1];
      tmp[8*ba[1:0] +: 8] = store_data_byte(d, i);
      expData[expN-1] = tmp;
      expLoad[8*i +: 8] = refMem[ba];
    end
    if (sz == 2'd0) expLoad = un ? {24'b0, expLoad[7:0]} : {{24{expLoad[7]}}, expLoad[7:0]};
    else if (sz == 2'd1) expLoad = un ? {16'b0, expLoad[15:0]} : {{16{expLoad[15]}}, expLoad[15:0]};

    @(negedge clk);
    op_valid = 1'b1; op_store = st; op_size = sz; op_unsigned = un; addr = a; store_data = d;
    @(posedge clk); #1;
    op_valid = 1'b0; op_store = ~st; op_size = 2'($urandom); op_unsigned = ~un;
    addr = $urandom; store_data = $urandom;

    gotN = 0; waitCnt = 0; inBeat = 1'b0; lvCount = 0; lvCycle = 0;
    faultCount = 0; endCycle = 0; lastLoad = 32'b0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge clk);
      if (load_valid) begin lvCount++; lvCycle = cyc; lastLoad = load_data; end
      if (fault) faultCount++;
      if (stallAt > 0 && cyc >= stallAt && cyc < stallAt + 2) begin
        clk_enable = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        checkOutput("stallReq", 64'(mem_req), 64'd1);
        checkOutput("stallAddr", 64'(mem_addr), 64'(beatAddr));
        checkOutput("stallBusy", 64'(busy), 64'd1);
        continue;
      end
      clk_enable = 1'b1; mem_ack = 1'b0;
      if (!busy) begin endCycle = cyc; break; end
      if (mem_req) begin
        if (!inBeat) begin inBeat = 1'b1; beatAddr = mem_addr; waitCnt = 0; end
        else checkOutput("addrStable", 64'(mem_addr), 64'(beatAddr));
        if (waitCnt == ackDelay) begin
          mem_ack = 1'b1; inBeat = 1'b0;
          if (gotN < 4) begin
            gotAddr[gotN] = mem_addr; gotMask[gotN] = mem_wmask;
            gotData[gotN] = mem_wdata; gotWe[gotN] = mem_we; gotN++;
          end
          if (mem_we) begin
            tmp = busMem[mem_addr];
            for (int l = 0; l < 4; l++) if (mem_wmask[l]) tmp[8*l +: 8] = mem_wdata[8*l +: 8];
            busMem[mem_addr] = tmp;
            mem_rdata = $urandom;
          end else begin
            mem_rdata = busMem[mem_addr];
          end
        end else begin
          waitCnt++;
        end
      end
    end
    clk_enable = 1'b1; mem_ack = 1'b0;

    expLv = expN * (ackDelay + 1) + 1 + ((stallAt > 0) ? 2 : 0);
    checkOutput("finished", 64'(endCycle != 0), 64'd1);
    checkOutput("beatCount", 64'(gotN), 64'(expN));
    for (int i = 0; i < expN && i < gotN; i++) begin
      checkOutput("beatAddr", 64'(gotAddr[i]), 64'(expAddr[i]));
      checkOutput("beatWe", 64'(gotWe[i]), 64'(st));
      checkOutput("beatMask", 64'(gotMask[i]), 64'(expMask[i]));
      if (st) begin
        for (int l = 0; l < 4; l++) bits[8*l +: 8] = {8{expMask[i][l]}};
        checkOutput("beatData", 64'(gotData[i] & bits), 64'(expData[i]));
      end
    end
    checkOutput("faultPulse", 64'(faultCount), 64'd0);
    checkOutput("busyLowCycle", 64'(endCycle), 64'(expLv + 1));
    if (st) begin
      checkOutput("storeNoLoad", 64'(lvCount), 64'd0);
      for (int i = 0; i < nBytes; i++) refMem[a + 32'(i)] = store_data_byte(d, i);
    end else begin
      checkOutput("loadPulses", 64'(lvCount), 64'd1);
      checkOutput("loadCycle", 64'(lvCycle), 64'(expLv));
      checkOutput("loadData", 64'(lastLoad), 64'(expLoad));
    end
  endtask

  function automatic logic [7:0] store_data_byte(input logic [31:0] d, input int i);
    return d[8*i +: 8];
  endfunction

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] ld;
    int faults, reqs, lvs, fCyc;

    rst = 1'b1; clk_enable = 1'b1; op_valid = 1'b0; op_store = 1'b0; op_size = 2'd0;
    op_unsigned = 1'b0; addr = 32'b0; store_data = 32'b0; mem_ack = 1'b0; mem_rdata = 32'b0;
    u1OpValid = 1'b0; u1MemAck = 1'b0;
    for (int w = 0; w <= 256; w++) setWord(30'(w), $urandom);
    setWord(30'h3FFFFFFF, $urandom);

    repeat (2) @(negedge clk);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstReq", 64'(mem_req), 64'd0);
    checkOutput("rstWe", 64'(mem_we), 64'd0);
    checkOutput("rstValid", 64'(load_valid), 64'd0);
    checkOutput("rstFault", 64'(fault), 64'd0);
    checkOutput("rstAddr", 64'(mem_addr), 64'd0);
    checkOutput("rstWdata", 64'(mem_wdata), 64'd0);
    checkOutput("rstMask", 64'(mem_wmask), 64'd0);
    checkOutput("rstData", 64'(load_data), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    setWord(30'h40, 32'hDEADBEEF);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 0, ld);
    checkOutput("wordLoad", 64'(ld), 64'hDEADBEEF);
    setWord(30'h40, 32'h80FFFFFF);
    applyStimulus(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, 0, ld);
    checkOutput("byteSigned", 64'(ld), 64'hFFFFFF80);
    applyStimulus(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1, 0, ld);
    checkOutput("byteUnsigned", 64'(ld), 64'h00000080);

    applyStimulus(1'b1, 2'd2, 1'b0, 32'h202, 32'h11223344, 0, 0, ld);
    applyStimulus(1'b0, 2'd1, 1'b1, 32'h202, 32'h0, 0, 0, ld);
    checkOutput("storeLowHalf", 64'(ld), 64'h3344);
    applyStimulus(1'b0, 2'd1, 1'b1, 32'h204, 32'h0, 0, 0, ld);
    checkOutput("storeHighHalf", 64'(ld), 64'h1122);

    applyStimulus(1'b0, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0, 1, 0, ld);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h140, 32'h0, 3, 2, ld);

    for (int n = 0; n < 40; n++)
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    32'h100 + $urandom_range(0, 255), $urandom, $urandom_range(0, 2), 0, ld);

    // Reset while the second beat of a crossing load is on the bus.
    @(negedge clk);
    op_valid = 1'b1; op_store = 1'b0; op_size = 2'd2; op_unsigned = 1'b0; addr = 32'h1FE;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(negedge clk);
    checkOutput("rstBeat0Req", 64'(mem_req), 64'd1);
    mem_ack = 1'b1; mem_rdata = busMem[30'h7F];
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("rstAcc1Req", 64'(mem_req), 64'd1);
    checkOutput("rstAcc1Addr", 64'(mem_addr), 64'h80);
    rst = 1'b1;
    #1;
    checkOutput("rstReqDrop", 64'(mem_req), 64'd0);
    checkOutput("rstBusyDrop", 64'(busy), 64'd0);
    checkOutput("rstNoValid", 64'(load_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    lvs = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (load_valid) lvs++;
    end
    checkOutput("rstNoLoad", 64'(lvs), 64'd0);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h1FE, 32'h0, 0, 0, ld);

    // Crossing request on the no-split instance must fault without a bus cycle.
    @(negedge clk);
    u1OpValid = 1'b1; op_store = 1'b0; op_size = 2'd1; op_unsigned = 1'b0; addr = 32'hFFFFFFFF;
    @(posedge clk); #1;
    u1OpValid = 1'b0;
    faults = 0; reqs = 0; lvs = 0; fCyc = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (u1Fault) begin faults++; fCyc = c; end
      if (u1MemReq) reqs++;
      if (u1LoadValid) lvs++;
    end
    checkOutput("nsFaultCount", 64'(faults), 64'd1);
    checkOutput("nsFaultCycle", 64'(fCyc), 64'd1);
    checkOutput("nsNoReq", 64'(reqs), 64'd0);
    checkOutput("nsNoLoad", 64'(lvs), 64'd0);
    checkOutput("nsIdle", 64'(u1Busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory stage sitting directly downstream of the control unit, in pipeline stage s2 ("mem").
- Takes a decoded load/store request (ALU address, store data, size, signedness) and drives a word-wide request/acknowledge data-memory bus.
- Splits misaligned accesses into two word transactions, returns sign- or zero-extended load data, and raises busy so the control unit can hold the pipeline (mem_in_use).

Parameters:
SPLIT_MISALIGNED, 1, 1 = misaligned accesses are split into two word transactions; 0 = misaligned accesses raise fault and do no memory transaction.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
clk_enable  in  1  global stall; when low, every register in the block holds
op_valid  in  1  request present
op_store  in  1  1 = store, 0 = load
op_size  in  2  0 = byte, 1 = half, 2 = word (3 = reserved, treated as word)
op_unsigned  in  1  zero-extend loads
addr  in  32  byte address from ALU
store_data  in  32  store value, LSB-aligned
busy  out  1  block not idle; request must be held
load_data  out  32  extended load result
load_valid  out  1  one-cycle pulse, load_data valid
fault  out  1  one-cycle pulse, misaligned access rejected (SPLIT_MISALIGNED=0)
mem_req  out  1  bus request
mem_we  out  1  bus write
mem_addr  out  30  word address
mem_wdata  out  32  write data, byte-lane aligned
mem_wmask  out  4  byte-lane enables (bit n = byte n)
mem_ack  in  1  bus acknowledge
mem_rdata  in  32  read data

Behaviour:
- Reset (asynchronous): state IDLE; busy, load_valid, fault, mem_req and mem_we = 0; load_data, mem_addr, mem_wdata and mem_wmask = 0.
- Reset mid-transaction drops mem_req immediately and discards the operation.
- All state updates are qualified by clk_enable. With clk_enable low, outputs hold and mem_ack is ignored.
- FSM states: IDLE, ACC0, ACC1, DONE. busy = (state != IDLE). All outputs are registered.
- Acceptance:
  - In IDLE, an edge with op_valid & clk_enable captures op_store, op_size, op_unsigned, addr and store_data, then moves to ACC0.
  - op_valid is ignored outside IDLE.
- Beat computation:
  - off = addr[1:0]; bytes = 1, 2 or 4 by size.
  - Crossing occurs when off + bytes > 4.
  - Beat 0: mem_addr = addr[31:2]; mask = ((1<<bytes)-1) << off, truncated to 4 bits; wdata = store_data << (8*off).
  - Beat 1: mem_addr = addr[31:2] + 1, wrapping 30'h3FFFFFFF -> 0; mask = the remaining upper lanes shifted down to lane 0; wdata = store_data >> (8*(4-off)).
- ACC0:
  - mem_req = 1, mem_we = op_store; signals are held stable until acknowledged.
  - On an edge with mem_ack: go to ACC1 if crossing, else DONE.
  - For loads, the read bytes are latched on that edge.
- ACC1: drives beat 1. On mem_ack it goes to DONE; mem_req deasserts on that edge.
- DONE:
  - Loads: load_valid = 1 for exactly one cycle, with load_data assembled from beat bytes, shifted to the LSB, and sign-extended from bit 7 or 15 unless op_unsigned (word loads unchanged).
  - Stores: no pulse.
  - Next edge goes to IDLE.
- mem_wmask and mem_wdata are don't-care for loads but are driven as for stores. mem_we = 0 on loads.
- SPLIT_MISALIGNED=0 with a crossing request: no mem_req; DONE with fault = 1 for one cycle, load_valid = 0.
- Latency: aligned access with mem_ack in the first request cycle gives accept T, mem_req high in T+1, load_valid in T+2, busy low in T+3. Each wait cycle on mem_ack adds one cycle. A crossing access adds at least one cycle.
- mem_ack while mem_req is low is ignored.

Test Plan:
- Aligned word load, addr=0x100, mem_rdata=0xDEADBEEF, ack immediate -> one beat at mem_addr=0x40, mem_we=0; load_valid pulse at T+2 with load_data=0xDEADBEEF.
- Signed byte load, addr=0x103, rdata=0x80FFFFFF -> 0xFFFFFF80; same with op_unsigned=1 -> 0x00000080.
- Misaligned word store, addr=0x202, data=0x11223344 -> beat 0: mem_addr=0x80, mask=4'b1100, wdata[31:16]=0x3344; beat 1: mem_addr=0x81, mask=4'b0011, wdata[15:0]=0x1122; no load_valid.
- Misaligned half load at addr=0xFFFFFFFF -> beat 1 mem_addr wraps to 0. Same request with SPLIT_MISALIGNED=0 -> fault pulse, no mem_req.
- Ack delayed 3 cycles, plus clk_enable low for 2 cycles mid-wait while mem_ack is high -> mem_req and mem_addr stable throughout, ack ignored while disabled, busy held, single load_valid.
- rst asserted during ACC1 -> mem_req low immediately, busy=0, no load_valid. A new op after reset completes normally.
